exu_alu_stage: RTL

- Execute-stage ALU unit of the NPC core. It sits between the ID/EX issue handshake and the writeback (WBU) handshake.
- Accepts decoded RV32I integer ops with operands and a destination tag, and computes the result in one cycle. Shift ops go through the core's 32-bit combinational barrel shifter.
- Presents the registered result to WBU over valid/ready, with a 2-entry skid buffer so issue never sees a combinational ready path.

---
 rtl/exu_pkg.sv | 32 +++
 rtl/exu_alu_stage_barrel_shifter.sv | 37 +++
 rtl/exu_alu_stage.sv | 122 ++++++++++++
 3 files changed

// File: rtl/exu_pkg.sv
// Shared definitions for the execute-stage ALU: op encodings and the entry
// record held by the result buffers.
package exu_pkg;

   localparam int EXU_OP_W  = 4;
   localparam int EXU_TAG_W = 5;

   localparam logic [EXU_OP_W-1:0] ALU_ADD  = 4'd0;
   localparam logic [EXU_OP_W-1:0] ALU_SUB  = 4'd1;
   localparam logic [EXU_OP_W-1:0] ALU_SLL  = 4'd2;
   localparam logic [EXU_OP_W-1:0] ALU_SLT  = 4'd3;
   localparam logic [EXU_OP_W-1:0] ALU_SLTU = 4'd4;
   localparam logic [EXU_OP_W-1:0] ALU_XOR  = 4'd5;
   localparam logic [EXU_OP_W-1:0] ALU_SRL  = 4'd6;
   localparam logic [EXU_OP_W-1:0] ALU_SRA  = 4'd7;
   localparam logic [EXU_OP_W-1:0] ALU_OR   = 4'd8;
   localparam logic [EXU_OP_W-1:0] ALU_AND  = 4'd9;

   // First code past the defined set; everything from here up is illegal.
   localparam logic [EXU_OP_W-1:0] ALU_ILLEGAL_MIN = 4'd10;

   typedef struct packed {
      logic [31:0]          result;
      logic [EXU_TAG_W-1:0] tag;
      logic                 illegal;
   } entry_t;

   function automatic logic op_is_illegal(input logic [EXU_OP_W-1:0] op);
      return (op >= ALU_ILLEGAL_MIN);
   endfunction

endpackage

// File: rtl/exu_alu_stage_barrel_shifter.sv
// 32-bit combinational barrel shifter, zero latency, no handshake.
// lr=0 shifts left; lr=1 shifts right, logical (la=0) or arithmetic (la=1).
module BarrelShifter (
   input  logic [31:0] din,
   input  logic [4:0]  shamt,
   input  logic        lr,
   input  logic        la,
   output logic [31:0] dout
);

   function automatic logic [31:0] rev32(input logic [31:0] v);
      logic [31:0] r;
      r = '0;
      for (int k = 0; k < 32; k++) begin
         r[k] = v[31-k];
      end
      return r;
   endfunction

   logic        fill;
   logic [31:0] stg [6];

   // Left shifts reuse the right-shift network on a bit-reversed operand.
   assign fill   = lr & la & din[31];
   assign stg[0] = lr ? din : rev32(din);

   genvar i;
   generate
      for (i = 0; i < 5; i++) begin : g_stage
         localparam int S = 1 << i;
         assign stg[i+1] = shamt[i] ? {{S{fill}}, stg[i][31:S]} : stg[i];
      end
   endgenerate

   assign dout = lr ? stg[5] : rev32(stg[5]);

endmodule

// File: rtl/exu_alu_stage.sv
// Execute-stage ALU: result registered one cycle after issue, main + skid entry
// toward writeback; in_ready is a flop (skid empty), so no combinational ready path.
module exu_alu_stage
   import exu_pkg::*;
#(
   parameter int TAG_W = EXU_TAG_W,
   parameter int OP_W  = EXU_OP_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [OP_W-1:0]  in_op,
   input  logic [31:0]      in_src1,
   input  logic [31:0]      in_src2,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [31:0]      out_result,
   output logic [TAG_W-1:0] out_tag,
   output logic             out_illegal
);

   logic        main_vld_q, main_vld_d;
   logic        skid_vld_q, skid_vld_d;
   entry_t      main_q, main_d;
   entry_t      skid_q, skid_d;

   logic        shift_lr;
   logic        shift_la;
   logic [31:0] shift_out;
   logic [31:0] alu_res;
   entry_t      new_entry;
   logic        in_fire;
   logic        out_fire;

   assign shift_lr = (in_op == ALU_SRL) || (in_op == ALU_SRA);
   assign shift_la = (in_op == ALU_SRA);

   BarrelShifter u_shifter (
      .din   (in_src1),
      .shamt (in_src2[4:0]),
      .lr    (shift_lr),
      .la    (shift_la),
      .dout  (shift_out)
   );

   always_comb begin
      alu_res = '0;
      case (in_op)
         ALU_ADD:  alu_res = in_src1 + in_src2;
         ALU_SUB:  alu_res = in_src1 - in_src2;
         ALU_SLL:  alu_res = shift_out;
         ALU_SRL:  alu_res = shift_out;
         ALU_SRA:  alu_res = shift_out;
         ALU_SLT:  alu_res = {31'b0, ($signed(in_src1) < $signed(in_src2))};
         ALU_SLTU: alu_res = {31'b0, (in_src1 < in_src2)};
         ALU_XOR:  alu_res = in_src1 ^ in_src2;
         ALU_OR:   alu_res = in_src1 | in_src2;
         ALU_AND:  alu_res = in_src1 & in_src2;
         default:  alu_res = '0;
      endcase
   end

   always_comb begin
      new_entry         = '0;
      new_entry.result  = alu_res;
      new_entry.tag     = in_tag;
      new_entry.illegal = op_is_illegal(in_op);
   end

   assign in_ready = ~skid_vld_q;
   assign in_fire  = in_valid & in_ready;
   assign out_fire = main_vld_q & out_ready;

   // Main is refilled whenever it vacates; skid has priority to keep order.
   always_comb begin
      main_vld_d = main_vld_q;
      skid_vld_d = skid_vld_q;
      main_d     = main_q;
      skid_d     = skid_q;
      if (flush) begin
         main_vld_d = 1'b0;
         skid_vld_d = 1'b0;
      end else if (out_fire || !main_vld_q) begin
         if (skid_vld_q) begin
            main_d     = skid_q;
            main_vld_d = 1'b1;
            skid_vld_d = 1'b0;
         end else if (in_fire) begin
            main_d     = new_entry;
            main_vld_d = 1'b1;
         end else begin
            main_vld_d = 1'b0;
         end
      end else if (in_fire) begin
         skid_d     = new_entry;
         skid_vld_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         main_vld_q <= 1'b0;
         skid_vld_q <= 1'b0;
         main_q     <= '0;
         skid_q     <= '0;
      end else begin
         main_vld_q <= main_vld_d;
         skid_vld_q <= skid_vld_d;
         main_q     <= main_d;
         skid_q     <= skid_d;
      end
   end

   assign out_valid   = main_vld_q;
   assign out_result  = main_q.result;
   assign out_tag     = main_q.tag;
   assign out_illegal = main_q.illegal;

endmodule
